odd_parity_frame_tx: RTL and testbench

//  Serial frame transmitter that sequences the odd-parity generator datapath.

---
 rtl/odd_parity_tx_pkg.sv | 18 +
 rtl/odd_parity_gen.sv | 12 +
 rtl/odd_parity_frame_tx.sv | 140 ++++++++++++++
 tb/tb_odd_parity_frame_tx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/odd_parity_tx_pkg.sv
// Shared types and line levels for the odd-parity serial frame transmitter.
package odd_parity_tx_pkg;

    // Frame sequencing states; STOP may loop straight back to START.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Serial line level while nothing is being sent.
    localparam logic LINE_IDLE = 1'b1;
    // Serial line level of the start bit.
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/odd_parity_gen.sv
// Combinational odd-parity generator: output makes the total count of ones odd.
module odd_parity_gen #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);

    // XNOR reduction yields 1 when data_i holds an even number of ones.
    assign parity_o = ~^data_i;

endmodule

// File: rtl/odd_parity_frame_tx.sv
// Serial frame transmitter: start(0), data LSB-first, odd parity, stop(1).
// One frame in flight; a new word may be accepted on the last STOP cycle.
module odd_parity_frame_tx
    import odd_parity_tx_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(WIDTH - 1);

    tx_state_e          state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               par_w;
    logic               baud_last;

    odd_parity_gen #(
        .WIDTH(WIDTH)
    ) u_par (
        .data_i  (data_in),
        .parity_o(par_w)
    );

    assign tx_out = tx_q;
    assign busy   = busy_q;

    // State, counters, shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state, bit timing, handshake ready and end-of-frame pulse.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        in_ready   = 1'b0;
        frame_done = 1'b0;
        baud_last  = (baud_q == BAUD_MAX);

        // Baud counter free-runs 0..CLKS_PER_BIT-1 while a frame is on the line.
        if (state_q != IDLE) begin
            baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                baud_d   = '0;
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == BIT_MAX) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (baud_last) begin
                    state_d = STOP;
                    tx_d    = LINE_IDLE;
                end
            end
            STOP: begin
                if (baud_last) begin
                    in_ready   = 1'b1;
                    frame_done = 1'b1;
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = LINE_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // An accepted word starts a frame immediately, overriding any STOP->IDLE exit.
        if (in_valid && in_ready) begin
            state_d = START;
            tx_d    = START_LVL;
            busy_d  = 1'b1;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = data_in;
            par_d   = par_w;
        end
    end

endmodule

// File: tb/tb_odd_parity_frame_tx.sv
// Directed bench for odd_parity_frame_tx: a 4-bit/4-clk instance and an 8-bit/1-clk instance.
module tb_odd_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data_a;
    logic       vld_a, ready_a, tx_a, busy_a, done_a;
    logic [7:0] data_b;
    logic       vld_b, ready_b, tx_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    odd_parity_frame_tx #(.WIDTH(4), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_a), .in_valid(vld_a),
        .in_ready(ready_a), .tx_out(tx_a), .busy(busy_a), .frame_done(done_a)
    );

    odd_parity_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_b), .in_valid(vld_b),
        .in_ready(ready_b), .tx_out(tx_b), .busy(busy_b), .frame_done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_tx"},    tx_a,    1'b1);
        chk({tag, "_busy"},  busy_a,  1'b0);
        chk({tag, "_ready"}, ready_a, 1'b1);
        chk({tag, "_done"},  done_a,  1'b0);
    endtask

    // Handshake a word into instance A; returns at the sample point of frame cycle 1.
    task automatic send_a(input string tag, input logic [3:0] d);
        int n = 0;
        while (!ready_a && n < 100) begin
            tick;
            n++;
        end
        chk({tag, "_hs_ready"}, ready_a, 1'b1);
        data_a = d;
        vld_a  = 1'b1;
        tick;
        vld_a  = 1'b0;
    endtask

    task automatic send_b(input string tag, input logic [7:0] d);
        int n = 0;
        while (!ready_b && n < 100) begin
            tick;
            n++;
        end
        chk({tag, "_hs_ready"}, ready_b, 1'b1);
        data_b = d;
        vld_b  = 1'b1;
        tick;
        vld_b  = 1'b0;
    endtask

    // Walk a whole frame; pat holds serial bits first-sent in the MSB position.
    // Ends at the sample point of the last STOP cycle.
    task automatic frame(input string tag, input bit sel_b, input logic [15:0] pat,
                         input int nbits, input int cpb);
        int   len;
        logic tx, bz, dn, rd;
        len = nbits * cpb;
        for (int k = 1; k <= len; k++) begin
            tx = sel_b ? tx_b    : tx_a;
            bz = sel_b ? busy_b  : busy_a;
            dn = sel_b ? done_b  : done_a;
            rd = sel_b ? ready_b : ready_a;
            chk($sformatf("%s_tx_c%0d", tag, k),    tx, pat[nbits - 1 - (k - 1) / cpb]);
            chk($sformatf("%s_busy_c%0d", tag, k),  bz, 1'b1);
            chk($sformatf("%s_done_c%0d", tag, k),  dn, (k == len));
            chk($sformatf("%s_ready_c%0d", tag, k), rd, (k == len));
            if (k < len) tick;
        end
    endtask

    initial begin
        // Reset held 3 cycles with a word offered.
        rst_n  = 1'b0;
        vld_a  = 1'b1;
        data_a = 4'hF;
        vld_b  = 1'b0;
        data_b = 8'h00;
        repeat (3) begin
            tick;
            chk_idle_a("rst");
            chk("rst_b_tx",   tx_b,   1'b1);
            chk("rst_b_busy", busy_b, 1'b0);
        end
        rst_n = 1'b1;
        vld_a = 1'b0;
        repeat (4) begin
            tick;
            chk_idle_a("post_rst");
        end

        // 4'b1011: start 0, data 1,1,0,1, parity 0, stop 1.
        send_a("t2", 4'b1011);
        frame("t2", 1'b0, 16'b0110101, 7, 4);
        tick;
        chk_idle_a("t2_end");

        // Parity edge cases: all zeros and all ones both need parity 1; a single one needs 0.
        send_a("t3_0", 4'h0);
        frame("t3_0", 1'b0, 16'b0000011, 7, 4);
        tick;
        send_a("t3_f", 4'hF);
        frame("t3_f", 1'b0, 16'b0111111, 7, 4);
        tick;
        send_a("t3_1", 4'h1);
        frame("t3_1", 1'b0, 16'b0100001, 7, 4);
        tick;
        chk_idle_a("t3_end");

        // Back-to-back with in_valid held: 4'h5 then 4'hA, word changed while not ready.
        data_a = 4'h5;
        vld_a  = 1'b1;
        tick;
        data_a = 4'hA;
        frame("t4a", 1'b0, 16'b0101011, 7, 4);
        tick;
        vld_a = 1'b0;
        frame("t4b", 1'b0, 16'b0010111, 7, 4);
        tick;
        chk_idle_a("t4_end");

        // Abort during DATA bit 2 (frame cycles 13..16) of 4'h3.
        send_a("t5", 4'h3);
        repeat (13) tick;
        chk("t5_mid_tx",   tx_a,   1'b0);
        chk("t5_mid_busy", busy_a, 1'b1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk_idle_a("t5_abort");
        repeat (30) begin
            tick;
            chk("t5_quiet_done", done_a, 1'b0);
            chk("t5_quiet_busy", busy_a, 1'b0);
        end
        send_a("t5_6", 4'h6);
        frame("t5_6", 1'b0, 16'b0011011, 7, 4);
        tick;
        chk_idle_a("t5_end");

        // 8'h80 on the one-clock-per-bit instance: 0, 0000000 1, parity 0, stop 1.
        send_b("t6", 8'h80);
        frame("t6", 1'b1, 16'b00000000101, 11, 1);
        tick;
        chk("t6_end_busy",  busy_b,  1'b0);
        chk("t6_end_tx",    tx_b,    1'b1);
        chk("t6_end_ready", ready_b, 1'b1);
        chk("t6_end_done",  done_b,  1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
